instr_fetch_unit: RTL



---
 rtl/ifetch_pkg.sv | 8 +
 rtl/fetch_watchdog.sv | 17 +
 rtl/instr_fetch_unit.sv | 73 +++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
package ifetch_pkg;
  localparam int IW = 10;
  localparam int PCW = 8;
  localparam logic [IW-1:0] NOP_INSTR = 10'b1111_000000;
  localparam logic [3:0] OPC_JMP = 4'b1001;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, RESOLVE, HALT} state_t;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts WAIT cycles without read data and flags expiry on the last allowed one.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = tick && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (tick) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch sequencer feeding one instruction per ISSUE cycle.
// Optional read timeout enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic           imem_rd,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  input  logic           imem_valid,
  output logic [IW-1:0]  instruction,
  output logic           instr_valid,
  input  logic           load_PC,
  input  logic [PCW-1:0] pc_value,
  output logic [PCW-1:0] pc,
  output logic           halted,
  output logic           fetch_err
);
  localparam logic [PCW:0] DEPTH = (PCW+1)'(PROG_DEPTH);
  if (PROG_DEPTH < 1 || PROG_DEPTH > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("instr_fetch_unit: parameter out of range");
  end
  state_t state, state_n;
  logic [PCW:0] target;
  logic bad, timeout;
`ifdef IFETCH_TIMEOUT_EN
  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clear(state == FETCH),
    .tick(state == WAIT && !imem_valid),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  assign imem_addr = pc;
  always_comb begin
    target = load_PC ? {1'b0, pc_value} : {1'b0, pc} + 9'd1;
    bad = target >= DEPTH;
    state_n = state == IDLE    ? (run ? FETCH : IDLE)
            : state == FETCH   ? WAIT
            : state == WAIT    ? (imem_valid ? ISSUE : timeout ? HALT : WAIT)
            : state == ISSUE   ? RESOLVE
            : state == RESOLVE ? (bad ? HALT : FETCH)
            : HALT;
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      imem_rd     <= 1'b0;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_n;
      imem_rd     <= state_n == FETCH;
      instr_valid <= state_n == ISSUE;
      instruction <= state_n == ISSUE ? imem_data : NOP_INSTR;
      halted      <= state_n == HALT;
      if (state == RESOLVE) pc <= target[PCW-1:0];
      if (timeout || (state == RESOLVE && load_PC && bad)) fetch_err <= 1'b1;
    end
  end
endmodule
